forward_ctrl: RTL and testbench

//  Forwarding/hazard controller for the 5-stage MIPS pipeline; produces the 2-bit selects consumed by
//  the 3:1 operand muxes in EX. Tracks destination tags internally (ID/EX, EX/MEM, MEM/WB shadows).

---
 rtl/fwd_pkg.sv | 45 ++++
 rtl/fwd_stage_reg.sv | 61 ++++++
 rtl/forward_ctrl.sv | 141 ++++++++++++++
 tb/tb_forward_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_pkg
// Description : Shared constants for the EX-stage forwarding/hazard
//               controller: operand-mux select encodings, the hard-wired
//               zero register, tag-bundle field widths and the select
//               priority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_pkg;

    // Default register-specifier width (MIPS: 32 registers)
    localparam int REG_ADDR_W_DEF = 5;

    // Width of the select driven to the 3:1 operand muxes in EX
    localparam int FWD_SEL_W = 2;
    typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

    // Operand-mux select encodings; 2'b11 is never driven
    localparam fwd_sel_t FWD_SEL_RF  = 2'b00;   // register-file read data
    localparam fwd_sel_t FWD_SEL_WB  = 2'b01;   // MEM/WB write-back data
    localparam fwd_sel_t FWD_SEL_MEM = 2'b10;   // EX/MEM ALU result

    // $0 is hard-wired to zero and must never be forwarded
    localparam int REG_ZERO = 0;

    // Control-bit widths carried in each shadow stage
    localparam int TAG_RW_W = 1;
    localparam int TAG_MR_W = 1;

    // Newest producer wins: an EX/MEM hit overrides a MEM/WB hit.
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
        fwd_sel_t sel;
        if (mem_hit) begin
            sel = FWD_SEL_MEM;
        end else if (wb_hit) begin
            sel = FWD_SEL_WB;
        end else begin
            sel = FWD_SEL_RF;
        end
        return sel;
    endfunction

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_stage_reg
// Description : One shadow stage of destination tag bundle (dst, regwrite,
//               memread). When i_load is low the stage captures a bubble
//               (all fields zero) instead of the incoming bundle.
// Revision    : 1.0 - initial release
// Ports       : clk, rst (async, active-high)
//               i_load            1 = capture inputs, 0 = capture bubble
//               i_dst/i_rw/i_mr   incoming tag bundle
//               o_dst/o_rw/o_mr   registered tag bundle
// ============================================================================
module fwd_stage_reg
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [REG_ADDR_W-1:0] i_dst,
    input  logic [TAG_RW_W-1:0]   i_rw,
    input  logic [TAG_MR_W-1:0]   i_mr,
    output logic [REG_ADDR_W-1:0] o_dst,
    output logic [TAG_RW_W-1:0]   o_rw,
    output logic [TAG_MR_W-1:0]   o_mr
);

    logic [REG_ADDR_W-1:0] dst_d, dst_q;
    logic [TAG_RW_W-1:0]   rw_d,  rw_q;
    logic [TAG_MR_W-1:0]   mr_d,  mr_q;

    always_comb begin
        dst_d = '0;
        rw_d  = '0;
        mr_d  = '0;
        if (i_load) begin
            dst_d = i_dst;
            rw_d  = i_rw;
            mr_d  = i_mr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_q <= '0;
            rw_q  <= '0;
            mr_q  <= '0;
        end else begin
            dst_q <= dst_d;
            rw_q  <= rw_d;
            mr_q  <= mr_d;
        end
    end

    assign o_dst = dst_q;
    assign o_rw  = rw_q;
    assign o_mr  = mr_q;

endmodule : fwd_stage_reg
`default_nettype wire

// File: rtl/forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : forward_ctrl
// Description : Forwarding / load-use hazard controller for a 5-stage MIPS
//               pipeline. Keeps ID/EX, EX/MEM and MEM/WB tag shadows and
//               derives the EX operand-mux selects plus the front-end stall.
// Revision    : 1.0 - initial release
// Config      : FWD_BRANCH_EN (macro) - adds id_branch input and
//               br_fwd_a/br_fwd_b outputs for ID-stage branch compare.
// Ports       : clk, reset (async, active-high)
//               id_valid, id_rs, id_rt, id_uses_rt, id_dst, id_regwrite,
//               id_memread        - decoded fields of the ID instruction
//               stall             - hold PC and IF/ID, bubble into ID/EX
//               fwd_a, fwd_b      - EX operand selects (00 RF, 01 WB, 10 MEM)
// ============================================================================
module forward_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dst,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    output logic                  stall,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
`ifdef FWD_BRANCH_EN
    ,
    input  logic                  id_branch,
    output logic                  br_fwd_a,
    output logic                  br_fwd_b
`endif
);

    localparam logic [REG_ADDR_W-1:0] ZERO_TAG = REG_ADDR_W'(REG_ZERO);

    // ---------------- shadow stages ----------------
    logic [REG_ADDR_W-1:0] idex_dst, exmem_dst, memwb_dst;
    logic                  idex_rw,  exmem_rw,  memwb_rw;
    logic                  idex_mr,  exmem_mr,  memwb_mr;
    logic [REG_ADDR_W-1:0] idex_rs_d, idex_rs_q, idex_rt_d, idex_rt_q;
    logic                  w_idex_load;
    logic                  w_stall;

    // A stalled or invalid ID instruction enters EX as a bubble.
    assign w_idex_load = id_valid & ~w_stall;

    fwd_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_idex (
        .clk (clk), .rst (reset), .i_load (w_idex_load),
        .i_dst (id_dst), .i_rw (id_regwrite), .i_mr (id_memread),
        .o_dst (idex_dst), .o_rw (idex_rw), .o_mr (idex_mr)
    );

    // EX onward never freezes: these stages always advance.
    fwd_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_exmem (
        .clk (clk), .rst (reset), .i_load (1'b1),
        .i_dst (idex_dst), .i_rw (idex_rw), .i_mr (idex_mr),
        .o_dst (exmem_dst), .o_rw (exmem_rw), .o_mr (exmem_mr)
    );

    fwd_stage_reg #(.REG_ADDR_W(REG_ADDR_W)) u_memwb (
        .clk (clk), .rst (reset), .i_load (1'b1),
        .i_dst (exmem_dst), .i_rw (exmem_rw), .i_mr (exmem_mr),
        .o_dst (memwb_dst), .o_rw (memwb_rw), .o_mr (memwb_mr)
    );

    // Source tags of the EX instruction (only the ID/EX stage needs them)
    always_comb begin
        idex_rs_d = '0;
        idex_rt_d = '0;
        if (w_idex_load) begin
            idex_rs_d = id_rs;
            idex_rt_d = id_rt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_rs_q <= '0;
            idex_rt_q <= '0;
        end else begin
            idex_rs_q <= idex_rs_d;
            idex_rt_q <= idex_rt_d;
        end
    end

    // MEM/WB memread is carried for uniformity of the stage but not consumed.
    logic w_unused_mr;
    assign w_unused_mr = exmem_mr ^ memwb_mr;

    // ---------------- forwarding selects ----------------
    logic w_exmem_live, w_memwb_live, w_idex_live_ld;
    assign w_exmem_live   = exmem_rw & (exmem_dst != ZERO_TAG);
    assign w_memwb_live   = memwb_rw & (memwb_dst != ZERO_TAG);
    assign w_idex_live_ld = idex_mr  & (idex_dst  != ZERO_TAG);

    assign fwd_a = fwd_pick(w_exmem_live & (exmem_dst == idex_rs_q),
                            w_memwb_live & (memwb_dst == idex_rs_q));
    assign fwd_b = fwd_pick(w_exmem_live & (exmem_dst == idex_rt_q),
                            w_memwb_live & (memwb_dst == idex_rt_q));

    // ---------------- load-use stall ----------------
    // One cycle is enough: next cycle the load is in MEM and its data
    // reaches EX through the MEM/WB path.
    logic w_lu_stall;
    logic w_idex_src_hit;
    assign w_idex_src_hit = (idex_dst == id_rs) | (id_uses_rt & (idex_dst == id_rt));

    if (LOAD_USE_STALL) begin : g_lu_stall
        assign w_lu_stall = id_valid & w_idex_live_ld & w_idex_src_hit;
    end else begin : g_no_lu_stall
        assign w_lu_stall = 1'b0;
    end

`ifdef FWD_BRANCH_EN
    // ID-stage branch compare: ALU results one stage ahead must wait a cycle;
    // a load needs two (second cycle caught while it sits in EX/MEM).
    logic w_br_stall;
    logic w_exmem_src_hit;
    assign w_exmem_src_hit = (exmem_dst == id_rs) | (id_uses_rt & (exmem_dst == id_rt));
    assign w_br_stall = id_valid & id_branch &
                        ((idex_rw & (idex_dst != ZERO_TAG) & w_idex_src_hit) |
                         (exmem_mr & (exmem_dst != ZERO_TAG) & w_exmem_src_hit));
    assign br_fwd_a = w_exmem_live & (exmem_dst == id_rs);
    assign br_fwd_b = w_exmem_live & (exmem_dst == id_rt);
    assign w_stall  = w_lu_stall | w_br_stall;
`else
    assign w_stall  = w_lu_stall;
`endif

    assign stall = w_stall;

endmodule : forward_ctrl
`default_nettype wire

// File: tb/tb_forward_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_ctrl
// Description : Directed self-checking bench for forward_ctrl. Each step
//               drives one ID instruction on the falling edge; outputs are
//               checked after the inputs settle, away from the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_uses_rt, id_regwrite, id_memread;
    logic       stall;
    logic [1:0] fwd_a, fwd_b;
`ifdef FWD_BRANCH_EN
    logic       id_branch;
    logic       br_fwd_a, br_fwd_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forward_ctrl #(.REG_ADDR_W(5), .LOAD_USE_STALL(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_dst      (id_dst),
        .id_regwrite (id_regwrite),
        .id_memread  (id_memread),
        .stall       (stall),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b)
`ifdef FWD_BRANCH_EN
        ,
        .id_branch   (id_branch),
        .br_fwd_a    (br_fwd_a),
        .br_fwd_b    (br_fwd_b)
`endif
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Present one instruction in ID on the falling edge.
    task automatic drive(input logic v, input int rs, input int rt, input logic ur,
                         input int dst, input logic rw, input logic mr);
        @(negedge clk);
        id_valid    = v;
        id_rs       = 5'(rs);
        id_rt       = 5'(rt);
        id_uses_rt  = ur;
        id_dst      = 5'(dst);
        id_regwrite = rw;
        id_memread  = mr;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        repeat (3) nop();
    endtask

    initial begin
        reset       = 1'b1;
        id_valid    = 1'b0;
        id_rs       = '0;
        id_rt       = '0;
        id_dst      = '0;
        id_uses_rt  = 1'b0;
        id_regwrite = 1'b0;
        id_memread  = 1'b0;
`ifdef FWD_BRANCH_EN
        id_branch   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {1'b0, stall}, 2'b00);
        chk("reset_fwd_a", fwd_a, 2'b00);
        chk("reset_fwd_b", fwd_b, 2'b00);
        @(negedge clk);
        reset = 1'b0;

        // 1: add $3,$1,$2 ; sub $4,$3,$5
        drive(1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0);
        drive(1'b1, 3, 5, 1'b1, 4, 1'b1, 1'b0);
        chk("t1_no_stall", {1'b0, stall}, 2'b00);
        nop();
        chk("t1_fwd_a", fwd_a, 2'b10);
        chk("t1_fwd_b", fwd_b, 2'b00);
        flush();

        // 2: add $3 ; nop ; or $6,$5,$3
        drive(1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0);
        nop();
        drive(1'b1, 5, 3, 1'b1, 6, 1'b1, 1'b0);
        nop();
        chk("t2_fwd_a", fwd_a, 2'b00);
        chk("t2_fwd_b", fwd_b, 2'b01);
        flush();

        // 3: add $3 ; add $3 ; and $7,$3,$3
        drive(1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0);
        drive(1'b1, 1, 2, 1'b1, 3, 1'b1, 1'b0);
        drive(1'b1, 3, 3, 1'b1, 7, 1'b1, 1'b0);
        nop();
        chk("t3_fwd_a", fwd_a, 2'b10);
        chk("t3_fwd_b", fwd_b, 2'b10);
        flush();

        // 4: lw $2,0($1) ; add $4,$2,$5
        drive(1'b1, 1, 2, 1'b0, 2, 1'b1, 1'b1);
        drive(1'b1, 2, 5, 1'b1, 4, 1'b1, 1'b0);
        chk("t4_stall", {1'b0, stall}, 2'b01);
        drive(1'b1, 2, 5, 1'b1, 4, 1'b1, 1'b0);   // IF/ID held
        chk("t4_stall_drop", {1'b0, stall}, 2'b00);
        chk("t4_bubble_fwd_a", fwd_a, 2'b00);
        nop();
        chk("t4_fwd_a", fwd_a, 2'b01);
        chk("t4_fwd_b", fwd_b, 2'b00);
        flush();

        // 5a: add $0,$1,$2 ; sub $4,$0,$0
        drive(1'b1, 1, 2, 1'b1, 0, 1'b1, 1'b0);
        drive(1'b1, 0, 0, 1'b1, 4, 1'b1, 1'b0);
        nop();
        chk("t5_zero_fwd_a", fwd_a, 2'b00);
        chk("t5_zero_fwd_b", fwd_b, 2'b00);
        flush();

        // 5b: lw $2 ; addi $2,$2,1
        drive(1'b1, 1, 2, 1'b0, 2, 1'b1, 1'b1);
        drive(1'b1, 2, 2, 1'b0, 2, 1'b1, 1'b0);
        chk("t5_addi_stall", {1'b0, stall}, 2'b01);
        drive(1'b1, 2, 2, 1'b0, 2, 1'b1, 1'b0);
        chk("t5_addi_once", {1'b0, stall}, 2'b00);
        flush();

        // 5c: lw $2 ; addi $6,$7,1  -> independent
        drive(1'b1, 1, 2, 1'b0, 2, 1'b1, 1'b1);
        drive(1'b1, 7, 6, 1'b0, 6, 1'b1, 1'b0);
        chk("t5_indep", {1'b0, stall}, 2'b00);
        flush();

        // rt matches the load but is not read as a source
        drive(1'b1, 1, 2, 1'b0, 2, 1'b1, 1'b1);
        drive(1'b1, 7, 2, 1'b0, 9, 1'b1, 1'b0);
        chk("rt_unused", {1'b0, stall}, 2'b00);
        flush();

        // invalid ID slot never stalls
        drive(1'b1, 1, 2, 1'b0, 2, 1'b1, 1'b1);
        drive(1'b0, 2, 2, 1'b1, 4, 1'b1, 1'b0);
        chk("id_invalid", {1'b0, stall}, 2'b00);
        flush();

        // 6: add $9 ; lw $2,0($9) ; add $4,$2,$5 then reset mid-stall
        drive(1'b1, 1, 2, 1'b1, 9, 1'b1, 1'b0);
        drive(1'b1, 9, 2, 1'b0, 2, 1'b1, 1'b1);
        drive(1'b1, 2, 5, 1'b1, 4, 1'b1, 1'b0);
        chk("t6_pre_stall", {1'b0, stall}, 2'b01);
        chk("t6_pre_fwd_a", fwd_a, 2'b10);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_async_stall", {1'b0, stall}, 2'b00);
        chk("t6_async_fwd_a", fwd_a, 2'b00);
        chk("t6_async_fwd_b", fwd_b, 2'b00);
        @(posedge clk);
        #1;
        chk("t6_hold_stall", {1'b0, stall}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t6_rel_stall", {1'b0, stall}, 2'b00);
        @(posedge clk);
        #1;
        chk("t6_rel_fwd_a", fwd_a, 2'b00);
        chk("t6_rel_fwd_b", fwd_b, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_forward_ctrl
`default_nettype wire
